// File: rtl/fu_issue_scheduler.sv
// Round-robin issue scheduler: moves ready RS entries into per-FU registered issue slots.
// Optional issue-stall counter is built when FU_ISSUE_STALL_CNT_EN is defined.

`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 6
`endif

module fu_issue_scheduler #(
    parameter int unsigned NUM_REQ   = 8,
    parameter int unsigned NUM_OF_FU = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic [NUM_REQ*`ROB_SIZE_WIDTH-1:0]    req_tag,
    output logic [NUM_REQ-1:0]                    grant,
    input  logic [NUM_OF_FU-1:0]                  fu_ready,
    output logic [NUM_OF_FU-1:0]                  fu_valid,
    output logic [NUM_OF_FU*$clog2(NUM_REQ)-1:0]  fu_req_idx,
    output logic [NUM_OF_FU*`ROB_SIZE_WIDTH-1:0]  fu_tag,
    output logic [31:0]                           stall_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned TAG_W = `ROB_SIZE_WIDTH;

    logic [NUM_OF_FU-1:0] fu_valid_q, fu_valid_d;
    logic [IDX_W-1:0]     slot_idx_q [NUM_OF_FU];
    logic [IDX_W-1:0]     slot_idx_d [NUM_OF_FU];
    logic [TAG_W-1:0]     slot_tag_q [NUM_OF_FU];
    logic [TAG_W-1:0]     slot_tag_d [NUM_OF_FU];
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0]     tag_arr    [NUM_REQ];
    logic [NUM_REQ-1:0]   grant_c;
    logic [NUM_OF_FU-1:0] slot_used;
    logic [IDX_W-1:0]     scan_idx;
    logic                 found;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_tag_unpack
            assign tag_arr[g] = req_tag[g*TAG_W +: TAG_W];
        end
        for (g = 0; g < NUM_OF_FU; g++) begin : g_slot_pack
            assign fu_req_idx[g*IDX_W +: IDX_W] = slot_idx_q[g];
            assign fu_tag[g*TAG_W +: TAG_W]     = slot_tag_q[g];
        end
    endgenerate

    // Scan requesters from rr_ptr; each pending one takes the lowest unused free slot.
    always_comb begin
        grant_c    = '0;
        fu_valid_d = fu_valid_q & ~fu_ready;
        slot_idx_d = slot_idx_q;
        slot_tag_d = slot_tag_q;
        rr_ptr_d   = rr_ptr_q;
        slot_used  = '0;
        scan_idx   = '0;
        found      = 1'b0;
        if (flush) begin
            fu_valid_d = '0;
        end else if (!reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                scan_idx = rr_ptr_q + IDX_W'(i);
                found    = 1'b0;
                if (req[scan_idx]) begin
                    for (int unsigned k = 0; k < NUM_OF_FU; k++) begin
                        if (!found && !slot_used[k] && (!fu_valid_q[k] || fu_ready[k])) begin
                            found              = 1'b1;
                            slot_used[k]       = 1'b1;
                            grant_c[scan_idx]  = 1'b1;
                            fu_valid_d[k]      = 1'b1;
                            slot_idx_d[k]      = scan_idx;
                            slot_tag_d[k]      = tag_arr[scan_idx];
                            rr_ptr_d           = scan_idx + IDX_W'(1);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fu_valid_q <= '0;
            rr_ptr_q   <= '0;
            for (int unsigned k = 0; k < NUM_OF_FU; k++) begin
                slot_idx_q[k] <= '0;
                slot_tag_q[k] <= '0;
            end
        end else begin
            fu_valid_q <= fu_valid_d;
            rr_ptr_q   <= rr_ptr_d;
            for (int unsigned k = 0; k < NUM_OF_FU; k++) begin
                slot_idx_q[k] <= slot_idx_d[k];
                slot_tag_q[k] <= slot_tag_d[k];
            end
        end
    end

    assign grant    = grant_c;
    assign fu_valid = fu_valid_q;

`ifdef FU_ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counts cycles where work was pending but nothing could issue; saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (|req && (grant_c == '0) && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Randomized bench for fu_issue_scheduler against a queue-based behavioural model.
// Directed scenarios cover latency, fairness, backpressure, flush, wrap and stall counting.

`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 6
`endif

module tb_fu_issue_scheduler;

    localparam int NR = 8;
    localparam int NF = 2;
    localparam int IW = 3;
    localparam int TW = `ROB_SIZE_WIDTH;
`ifdef FU_ISSUE_STALL_CNT_EN
    localparam logic [63:0] STALL_EXP10 = 64'd10;
`else
    localparam logic [63:0] STALL_EXP10 = 64'd0;
`endif

    logic              clk;
    logic              reset;
    logic              flush;
    logic [NR-1:0]     req;
    logic [NR*TW-1:0]  req_tag;
    logic [NR-1:0]     grant;
    logic [NF-1:0]     fu_ready;
    logic [NF-1:0]     fu_valid;
    logic [NF*IW-1:0]  fu_req_idx;
    logic [NF*TW-1:0]  fu_tag;
    logic [31:0]       stall_cnt;

    fu_issue_scheduler #(.NUM_REQ(NR), .NUM_OF_FU(NF)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req        (req),
        .req_tag    (req_tag),
        .grant      (grant),
        .fu_ready   (fu_ready),
        .fu_valid   (fu_valid),
        .fu_req_idx (fu_req_idx),
        .fu_tag     (fu_tag),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit              m_valid [NF];
    int              m_idx   [NF];
    int              m_tag   [NF];
    int              m_rr;
    longint unsigned m_stall;
    logic [NR-1:0]   prev_grant;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NR*TW-1:0] rand_tags();
        logic [NR*TW-1:0] t;
        for (int e = 0; e < NR; e++) t[e*TW +: TW] = TW'($urandom);
        return t;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NF; k++) begin
            m_valid[k] = 1'b0;
            m_idx[k]   = 0;
            m_tag[k]   = 0;
        end
        m_rr       = 0;
        m_stall    = 0;
        prev_grant = '0;
    endtask

    // One cycle: drive inputs, check registered state and grant, advance model.
    task automatic step(input logic [NR-1:0] r, input logic [NR*TW-1:0] tg,
                        input logic [NF-1:0] rdy, input logic fl, input logic rs);
        logic [NR-1:0] eg;
        int            fq[$];
        int            e;
        int            k;
        int            last;
        @(negedge clk);
        reset    = rs;
        flush    = fl;
        req      = r;
        req_tag  = tg;
        fu_ready = rdy;
        #1;
        for (int s = 0; s < NF; s++) begin
            check_eq($sformatf("fu_valid[%0d]", s), 64'(fu_valid[s]), 64'(m_valid[s]));
            if (m_valid[s]) begin
                check_eq($sformatf("fu_req_idx[%0d]", s), 64'(fu_req_idx[s*IW +: IW]), 64'(m_idx[s]));
                check_eq($sformatf("fu_tag[%0d]", s), 64'(fu_tag[s*TW +: TW]), 64'(m_tag[s]));
            end
        end
        check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall));

        eg   = '0;
        last = -1;
        for (int s = 0; s < NF; s++) if (!m_valid[s] || rdy[s]) fq.push_back(s);
        for (int s = 0; s < NF; s++) if (rdy[s]) m_valid[s] = 1'b0;
        if (!rs && !fl) begin
            for (int i = 0; i < NR; i++) begin
                e = (m_rr + i) % NR;
                if (r[e] && fq.size() > 0) begin
                    k          = fq.pop_front();
                    eg[e]      = 1'b1;
                    m_valid[k] = 1'b1;
                    m_idx[k]   = e;
                    m_tag[k]   = int'(tg[e*TW +: TW]);
                    last       = e;
                end
            end
        end
        check_eq("grant", 64'(grant), 64'(eg));

`ifdef FU_ISSUE_STALL_CNT_EN
        if (!rs && !fl && r != 0 && eg == 0 && m_stall != 64'hFFFF_FFFF) m_stall++;
`endif
        if (fl) for (int s = 0; s < NF; s++) m_valid[s] = 1'b0;
        if (last >= 0) m_rr = (last + 1) % NR;
        prev_grant = eg;
        if (rs) model_reset();
    endtask

    initial begin
        logic [NR*TW-1:0] tg;
        logic [NR-1:0]    r;
        reset    = 1'b1;
        flush    = 1'b0;
        req      = '0;
        req_tag  = '0;
        fu_ready = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state, and grant suppressed while reset is high
        step('0, '0, '0, 1'b0, 1'b1);
        step(8'hFF, rand_tags(), 2'b11, 1'b0, 1'b1);
        check_eq("rst_grant", 64'(grant), 64'h0);

        // Single-cycle latency into both slots
        step(8'h06, rand_tags(), 2'b11, 1'b0, 1'b0);
        check_eq("t1_grant", 64'(grant), 64'h06);
        step(8'h09, rand_tags(), 2'b00, 1'b0, 1'b0);
        check_eq("t1_valid", 64'(fu_valid), 64'h3);
        check_eq("t1_idx", 64'(fu_req_idx), 64'({3'd2, 3'd1}));
        check_eq("full_grant", 64'(grant), 64'h0);
        step(8'h09, rand_tags(), 2'b01, 1'b0, 1'b0);
        check_eq("t1_rr3", 64'(grant), 64'h08);

        // Fairness with all requesters pending
        step('0, '0, '0, 1'b0, 1'b1);
        step(8'hFF, rand_tags(), 2'b11, 1'b0, 1'b0);
        check_eq("fair0", 64'(grant), 64'h03);
        step(8'hFF, rand_tags(), 2'b11, 1'b0, 1'b0);
        check_eq("fair1", 64'(grant), 64'h0C);
        step(8'hFF, rand_tags(), 2'b11, 1'b0, 1'b0);
        check_eq("fair2", 64'(grant), 64'h30);
        step(8'hFF, rand_tags(), 2'b11, 1'b0, 1'b0);
        check_eq("fair3", 64'(grant), 64'hC0);
        step(8'hFF, rand_tags(), 2'b11, 1'b0, 1'b0);
        check_eq("fair4", 64'(grant), 64'h03);

        // Backpressure on slot 0 holding tag 5
        step('0, '0, '0, 1'b0, 1'b1);
        tg = rand_tags();
        tg[0 +: TW] = TW'(5);
        step(8'h01, tg, 2'b11, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step(8'hFE, rand_tags(), 2'b10, 1'b0, 1'b0);
            check_eq("bp_tag0", 64'(fu_tag[0 +: TW]), 64'd5);
            check_eq("bp_valid0", 64'(fu_valid[0]), 64'd1);
            check_eq("bp_popcnt", 64'($countones(grant) <= 1), 64'd1);
        end

        // Flush overrides req and fu_ready
        step(8'h03, rand_tags(), 2'b11, 1'b0, 1'b0);
        step(8'h0F, rand_tags(), 2'b11, 1'b1, 1'b0);
        check_eq("flush_grant", 64'(grant), 64'h0);
        step('0, rand_tags(), 2'b00, 1'b0, 1'b0);
        check_eq("flush_valid", 64'(fu_valid), 64'h0);
        step(8'hFF, rand_tags(), 2'b11, 1'b0, 1'b0);

        // Wrap-around priority from rr_ptr=7
        step(8'h01, rand_tags(), 2'b00, 1'b1, 1'b0);
        step(8'h40, rand_tags(), 2'b00, 1'b0, 1'b0);
        check_eq("wrap_g6", 64'(grant), 64'h40);
        step(8'h81, rand_tags(), 2'b00, 1'b0, 1'b0);
        check_eq("wrap_g7", 64'(grant), 64'h80);
        step(8'h11, rand_tags(), 2'b01, 1'b0, 1'b0);
        check_eq("wrap_rr0", 64'(grant), 64'h01);

        // Stall counting with both slots stuck
        step('0, '0, '0, 1'b0, 1'b1);
        step(8'h03, rand_tags(), 2'b11, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) step(8'h01, rand_tags(), 2'b00, 1'b0, 1'b0);
        step('0, rand_tags(), 2'b00, 1'b0, 1'b0);
        check_eq("stall10", 64'(stall_cnt), STALL_EXP10);
        step('0, '0, '0, 1'b0, 1'b1);
        step('0, '0, '0, 1'b0, 1'b0);
        check_eq("stall_rst", 64'(stall_cnt), 64'h0);

        // Randomized traffic honouring the drop-after-grant contract
        for (int c = 0; c < 400; c++) begin
            r = NR'($urandom) & NR'($urandom | $urandom) & ~prev_grant;
            step(r, rand_tags(), NF'($urandom), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 63) == 0));
        end
        step('0, '0, '0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fu_issue_scheduler.md
# fu_issue_scheduler

Issue scheduler between the reservation station and the functional units. Each cycle it picks up to NUM_OF_FU ready-to-issue RS entries in round-robin order and loads them into per-FU issue slots. Each slot is a registered valid/ready handshake toward one FU. It drives the RS side of the FU interface (valid and tag fields) and returns one-hot grants so the RS can retire the issued entries.

## Interface

Parameters:
- NUM_REQ, 8 — number of RS entries (requesters); power of two, ≥2.
- NUM_OF_FU, 2 — number of functional units / issue slots; 1..NUM_REQ.

Ports:
- Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high.
- clk  input  1  — sole clock; all state updates on the rising edge.
- reset  input  1  — synchronous, active-high.
- flush  input  1  — pipeline flush (mispredict); synchronous.
- req  input  NUM_REQ  — bit i set: RS entry i is ready to issue.
- req_tag  input  NUM_REQ × `ROB_SIZE_WIDTH — ROB tag of each entry.
- grant  output  NUM_REQ  — combinational; bit i set: entry i is issued this cycle.
- fu_ready  input  NUM_OF_FU  — FU k accepts its slot this cycle.
- fu_valid  output  NUM_OF_FU  — registered; slot k holds an instruction.
- fu_req_idx  output  NUM_OF_FU × $clog2(NUM_REQ)  — RS entry index held in slot k.
- fu_tag  output  NUM_OF_FU × `ROB_SIZE_WIDTH  — ROB tag held in slot k.
- stall_cnt  output  32  — issue-stall counter (see Configuration).

## Operation

Slot freedom:
- Slot k is free this cycle when `!fu_valid[k] || fu_ready[k]`.
- A slot that transfers to its FU may be refilled in the same cycle.

Selection:
- Scan requesters from rr_ptr upward, wrapping modulo NUM_REQ.
- The first pending req goes to the lowest-index free slot, the second to the next free slot, and so on, until free slots or requests run out.
- Each requester receives at most one slot.

Grant and slot update:
- grant is one-hot per issued entry and has popcount ≤ number of free slots.
- grant is purely combinational from req, rr_ptr, fu_valid, fu_ready and flush.
- Assigned slot: fu_valid←1 and fu_req_idx/fu_tag are captured at the edge.
- Free slot with no assignment: fu_valid←0.
- Occupied slot with fu_ready=0: holds all of its fields unchanged.

Round-robin pointer:
- rr_ptr ← (highest-priority-order last granted index + 1) mod NUM_REQ.
- rr_ptr is unchanged when nothing is granted.

Flush:
- grant forced to 0.
- All fu_valid←0 at the edge.
- rr_ptr unchanged.
- Flush overrides any same-cycle fu_ready and req.

Reset:
- fu_valid=0, fu_req_idx=0, fu_tag=0, rr_ptr=0, stall_cnt=0, grant=0 while reset is high.
- Reset asserted mid-operation discards all slot contents at the next edge.

Requester contract:
- Requesters must drop req[i] the cycle after grant[i].
- The scheduler does not track entries already issued.

## Timing

- Latency: req[i] high in cycle n with a free slot → grant[i] in cycle n → fu_valid high from cycle n+1.
- Back-to-back: fu_valid & fu_ready in cycle n plus a pending req → the slot holds the new instruction in cycle n+1, with no bubble.
- Throughput: up to NUM_OF_FU issues per cycle.
- Backpressure: the slot payload is stable while fu_valid & !fu_ready.
- Wrap-around: with rr_ptr=NUM_REQ-1 and req bits at NUM_REQ-1 and 0, NUM_REQ-1 has priority, then 0.
- Boundaries:
  - All slots full and none ready → grant=0.
  - req=0 → grant=0 and rr_ptr held.

## Configuration

Macro `FU_ISSUE_STALL_CNT_EN`.

Defined:
- stall_cnt increments by 1 each cycle with |req=1, grant=0 and flush=0.
- The count saturates at 32'hFFFF_FFFF.
- Cleared only by reset; flush does not clear it.

Undefined:
- No counter logic is built.
- stall_cnt is tied to 0; the port remains.

## Test plan

1. Reset, then NUM_REQ=8, NUM_OF_FU=2, req=8'b0000_0110, fu_ready=2'b11:
   - cycle 0: grant=8'b0000_0110.
   - cycle 1: fu_valid=2'b11, fu_req_idx={2,1}, rr_ptr=3.
2. Fairness:
   - req=8'hFF held, fu_ready=2'b11 for 4 cycles.
   - Grant pairs are {0,1}, {2,3}, {4,5}, {6,7}; then wrap to {0,1}.
3. Backpressure:
   - Slot 0 valid with tag 5, fu_ready[0]=0 for 3 cycles.
   - fu_tag[0]=5 is held; only slot 1 accepts new grants; grant popcount ≤1.
4. Flush:
   - Both slots valid, flush=1 with req=8'h0F.
   - grant=0 in that cycle; fu_valid=2'b00 next cycle; rr_ptr unchanged.
5. Wrap priority:
   - rr_ptr=7, req=8'b1000_0001, one free slot.
   - grant=8'b1000_0000; then rr_ptr=0.
6. With `FU_ISSUE_STALL_CNT_EN` defined:
   - req=8'h01 and both slots stuck (fu_ready=0) for 10 cycles → stall_cnt=10.
   - Reset → stall_cnt=0.
   - Without the macro, stall_cnt=0 throughout.
